tt_um_seq_divider_hhrb98: RTL and testbench

- Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
- Inverse of the team's 4x4 array multiplier; can recover a 4-bit factor from an 8-bit product.
- Ships as a standalone TinyTapeout user tile with the standard tt_um port set.
- Handshake: start pulse in, busy/done flags out; result held until the next start.

---
 rtl/tt_um_seq_divider_hhrb98.sv | 91 +++++++++
 tb/tb_tt_um_seq_divider_hhrb98.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tt_um_seq_divider_hhrb98.sv
// Sequential restoring divider tile: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes on the start edge.
module tt_um_seq_divider_hhrb98 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic       start_q;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [4:0] pr;
  logic [7:0] quotient;
  logic [2:0] cnt;

  logic       start_edge;
  logic       sel;
  logic [4:0] pr_shift;
  logic [4:0] pr_sub;
  logic       pr_ge;
  logic       unused_pins;

  assign start_edge  = uio_in[4] & ~start_q;
  assign sel         = uio_in[5];
  assign unused_pins = &{1'b0, uio_in[7:6]};

  // Dividend is shifted left each iteration so its MSB is always the next bit to bring down.
  assign pr_shift = {pr[3:0], dividend[7]};
  assign pr_ge    = pr_shift >= {1'b0, divisor};
  assign pr_sub   = pr_shift - {1'b0, divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      pr       <= '0;
      quotient <= '0;
      cnt      <= '0;
    end else if (ena) begin
      start_q <= uio_in[4];
      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            dividend <= ui_in;
            divisor  <= uio_in[3:0];
            pr       <= '0;
            quotient <= '0;
            cnt      <= '0;
            state    <= S_RUN;
`ifdef DIV_ZERO_FAST_EN
            if (uio_in[3:0] == 4'd0) begin
              quotient <= '1;
              pr       <= 5'h0F;
              state    <= S_DONE;
            end
`endif
          end
        end
        S_RUN: begin
          dividend <= {dividend[6:0], 1'b0};
          quotient <= {quotient[6:0], pr_ge};
          pr       <= pr_ge ? pr_sub : pr_shift;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= S_DONE;
            // A zero divisor yields all-ones quotient naturally; the remainder is forced.
            if (divisor == 4'd0) pr <= 5'h0F;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = sel ? {4'b0000, pr[3:0]} : quotient;
  assign uio_out = {state == S_DONE, state == S_RUN, 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Directed self-checking bench for the sequential divider tile.
module tb_tt_um_seq_divider_hhrb98;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;
  int n;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 8;
`endif

  tt_um_seq_divider_hhrb98 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is raised before edge N and dropped just after it.
  task automatic pulse_start(input logic [7:0] a, input logic [3:0] b);
    ui_in  = a;
    uio_in = {3'b000, 1'b1, b};
    tick();
    uio_in[4] = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!uio_out[7] && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  task automatic chk_result(input string tag, input logic [7:0] q, input logic [3:0] r);
    uio_in[5] = 1'b0;
    #1 chk({tag, "_q"}, uo_out, q);
    uio_in[5] = 1'b1;
    #1 chk({tag, "_r"}, uo_out, {4'b0000, r});
    uio_in[5] = 1'b0;
    #1;
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] q, input logic [3:0] r, input int lat);
    int cnt;
    pulse_start(a, b);
    chk({tag, "_flags"}, uio_out, (lat == 0) ? 8'h80 : 8'h40);
    wait_done(cnt);
    chk({tag, "_lat"}, 8'(cnt), 8'(lat));
    chk_result(tag, q, r);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hC0);
    uio_in[5] = 1'b1;
    #1 chk("rst_rem", uo_out, 8'h00);
    uio_in[5] = 1'b0;

    run_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 8);
    repeat (3) tick();
    chk("hold_flags", uio_out, 8'h80);
    chk_result("hold", 8'd28, 4'd4);

    run_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 8);
    run_div("d143_13", 8'd143, 4'd13, 8'd11, 4'd0, 8);
    run_div("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 8);
    run_div("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 8);
    run_div("div0", 8'd9, 4'd0, 8'hFF, 4'hF, ZERO_LAT);

    // Second start at edge N+3 is ignored; first result still lands at N+8.
    pulse_start(8'd200, 4'd7);
    tick();
    tick();
    pulse_start(8'd50, 4'd5);
    chk("busy_ign", uio_out, 8'h40);
    wait_done(n);
    chk("ign_lat", 8'(n), 8'd5);
    chk_result("ign", 8'd28, 4'd4);
    run_div("d50_5", 8'd50, 4'd5, 8'd10, 4'd0, 8);

    // Reset in the middle of a run clears everything immediately.
    pulse_start(8'd100, 4'd3);
    repeat (4) tick();
    rst_n = 1'b0;
    #1 chk("mid_rst_uio", uio_out, 8'h00);
    chk("mid_rst_uo", uo_out, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_uio", uio_out, 8'h00);

    // ena low for 5 cycles mid-run stretches completion by exactly 5 cycles.
    pulse_start(8'd200, 4'd7);
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) tick();
    chk("ena_hold", uio_out, 8'h40);
    ena = 1'b1;
    wait_done(n);
    chk("ena_lat", 8'(n), 8'd5);
    chk_result("ena", 8'd28, 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
